// File: rtl/data_ram_arbiter_pkg.sv
// rtl/data_ram_arbiter_pkg.sv - shared port indices, word-address shift and response-slot type
package data_ram_arbiter_pkg;

   localparam logic PORT_HOST = 1'b0;
   localparam logic PORT_CPU  = 1'b1;

   // Byte address to word address: drop the two byte-lane bits.
   localparam int WORD_ADDR_SHIFT = 2;

   typedef struct packed {
      logic pending;
      logic owner;
   } rsp_slot_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - combinational two-way round-robin grant
module rr_arbiter2
   import data_ram_arbiter_pkg::*;
(
   input  logic valid0,
   input  logic valid1,
   input  logic last_grant,
   output logic grant0,
   output logic grant1
);

   // On contention the port that did not win last time goes first.
   always_comb begin
      grant0 = valid0 && (!valid1 || (last_grant == PORT_CPU));
      grant1 = valid1 && (!valid0 || (last_grant == PORT_HOST));
   end

endmodule

// File: rtl/data_ram_arbiter.sv
// rtl/data_ram_arbiter.sv - two-port round-robin access to a BlockRam with fixed-latency load responses
module data_ram_arbiter
   import data_ram_arbiter_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 16,
   parameter int WORD_WIDTH    = 32
) (
   input  logic                     clock,
   input  logic                     reset,

   input  logic                     req0_valid,
   output logic                     req0_ready,
   input  logic                     req0_write,
   input  logic [ADDRESS_WIDTH-1:0] req0_address,
   input  logic [WORD_WIDTH-1:0]    req0_write_data,
   output logic                     rsp0_valid,
   output logic [WORD_WIDTH-1:0]    rsp0_data,

   input  logic                     req1_valid,
   output logic                     req1_ready,
   input  logic                     req1_write,
   input  logic [ADDRESS_WIDTH-1:0] req1_address,
   input  logic [WORD_WIDTH-1:0]    req1_write_data,
   output logic                     rsp1_valid,
   output logic [WORD_WIDTH-1:0]    rsp1_data,

   output logic [ADDRESS_WIDTH-1:0] ram_address,
   output logic                     ram_write,
   output logic [WORD_WIDTH-1:0]    ram_write_data,
   input  logic [WORD_WIDTH-1:0]    ram_read_data,

   output logic                     busy
);

   logic                     last_grant;
   logic                     grant0;
   logic                     grant1;
   logic                     accept;
   logic                     win_port;
   logic                     win_write;
   logic [ADDRESS_WIDTH-1:0] win_address;
   logic [WORD_WIDTH-1:0]    win_write_data;
   rsp_slot_t                slot_e1;
   rsp_slot_t                slot_e2;

   rr_arbiter2 u_rr_arbiter2 (
      .valid0     (req0_valid),
      .valid1     (req1_valid),
      .last_grant (last_grant),
      .grant0     (grant0),
      .grant1     (grant1)
   );

   always_comb begin
      req0_ready     = grant0 && !reset;
      req1_ready     = grant1 && !reset;
      accept         = req0_ready || req1_ready;
      win_port       = req1_ready ? PORT_CPU : PORT_HOST;
      win_write      = req1_ready ? req1_write      : req0_write;
      win_address    = req1_ready ? req1_address    : req0_address;
      win_write_data = req1_ready ? req1_write_data : req0_write_data;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         last_grant     <= PORT_CPU;
         ram_write      <= 1'b0;
         ram_address    <= '0;
         ram_write_data <= '0;
      end else begin
         ram_write <= accept && win_write;
         if (accept) begin
            last_grant     <= win_port;
            ram_address    <= win_address >> WORD_ADDR_SHIFT;
            ram_write_data <= win_write_data;
         end
      end
   end

   // slot_e1 tracks a load whose address sits on the RAM port; slot_e2 one whose data is on ram_read_data.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         slot_e1 <= '0;
         slot_e2 <= '0;
      end else begin
         slot_e1.pending <= accept && !win_write;
         slot_e1.owner   <= win_port;
         slot_e2         <= slot_e1;
      end
   end

   always_comb begin
      rsp0_valid = slot_e2.pending && (slot_e2.owner == PORT_HOST);
      rsp1_valid = slot_e2.pending && (slot_e2.owner == PORT_CPU);
      rsp0_data  = ram_read_data;
      rsp1_data  = ram_read_data;
      busy       = slot_e1.pending || slot_e2.pending;
   end

endmodule
